md5_pad: RTL and testbench
==========================

// Module: md5_pad
// PURPOSE
//  Message front end for the MD5 compression core. Accepts a byte stream and emits MD5-padded
//  512-bit blocks in the core's block layout. Padding appends 0x80, then zeros, then the 64-bit
//  little-endian message bit length. Sits between the host byte source and the compression core.
//  Each emitted block is one compression round; blk_last marks the final block of a message.
// PARAMETERS
//  CNT_W      32     byte-counter width; bit length = {cnt,3'b000} zero-extended to 64 bits
//  MAX_BYTES  2**20  message byte limit; used only when MD5_PAD_MAXLEN_CHK_EN is defined
// PORTS
//  clk         in   1    clock; all state updates on posedge
//  rst         in   1    synchronous active-high reset
//  in_valid    in   1    input byte offered
//  in_ready    out  1    block accepts byte (handshake = in_valid & in_ready)
//  in_data     in   8    message byte
//  in_bytevld  in   1    in_data is real; 0 only with in_last (empty message / bare terminator)
//  in_last     in   1    final beat of message
//  blk_valid   out  1    blk_data holds a complete block
//  blk_ready   in   1    core accepts block (handshake = blk_valid & blk_ready)
//  blk_data    out  512  byte i of block at [8i+7:8i]; so MD5 word j = [32j+31:32j]
//  blk_last    out  1    block is final block of message (qualified by blk_valid)
//  err         out  1    sticky overflow flag (tied 0 without MD5_PAD_MAXLEN_CHK_EN)
// BEHAVIOUR
//  Reset: state=FILL, idx=0, cnt=0, buffer=0, in_ready=1, blk_valid=0, blk_last=0, err=0.
//  FILL: accept a byte into buffer[idx], idx++, cnt++ (when in_bytevld=1).
//   - idx wraps 63->0 on the 64th byte, not last: go to EMIT; blk_valid=1 next cycle; blk_last=0.
//   - Any in_last beat (in_bytevld 0 or 1): go to FIN; in_ready=0 from the next cycle.
//  FIN (1 cycle): buffer[idx]=0x80.
//   - idx<=55: also write the length into bytes 56..63; go to EMIT with blk_last=1.
//   - idx in 56..63: go to EMIT with blk_last=0, then LENBLK.
//   - Last byte accepted in cycle t => blk_valid=1 in cycle t+2.
//  EMIT: blk_valid=1 and blk_data stable until blk_ready.
//   - On handshake: buffer cleared to 0, idx=0.
//   - Next state: LENBLK if pending, FILL otherwise.
//   - cnt cleared when the handshake has blk_last=1.
//  LENBLK (1 cycle): bytes 56..63=length, bytes 0..55=0; go to EMIT with blk_last=1.
//  in_ready=1 only in FILL; blk_valid=1 only in EMIT. Input and output never handshake together.
//  Zeros come from clear-on-emit; no per-byte zero fill. No combinational path blk_ready->in_ready.
//  Length: 64-bit {cnt,3'b000}, little-endian, byte 56 = LSB. cnt saturates at all-ones.
//  rst mid-message or mid-EMIT: aborts the message; the partial block is discarded, not emitted.
// CONFIGURATION
//  MD5_PAD_MAXLEN_CHK_EN defined:
//   - A data byte arriving with cnt==MAX_BYTES sets err (sticky until rst).
//   - That byte and later data bytes are accepted and dropped.
//   - in_last still terminates with the length of the bytes kept.
//  Not defined: err tied 0; no limit check.
// STRUCTURE
//  md5_pkg holds:
//   - state enum typedef {FILL,FIN,EMIT,LENBLK}
//   - constants MD5_BLK_BYTES=64, MD5_LEN_OFS=56, MD5_PAD_BYTE=8'h80
//   - function len_bytes(cnt) giving the 64-bit little-endian bit length
//  One sub-module: md5_pad_buf (64x8 buffer with byte write, 8-byte length write, clear).
// TESTING
//  "abc" (61,62,63, last on 63) => one block; blk_data[31:0]=32'h80636261,
//   blk_data[479:448]=32'h18, other bits 0, blk_last=1.
//  Empty (in_bytevld=0,in_last=1) => blk_data=512'h80, blk_last=1, blk_valid 2 cycles after beat.
//  55 bytes 0x00..0x36 => one block; byte55=0x80, [479:448]=32'h1B8.
//  56 bytes => two blocks; block1 byte56=0x80, blk_last=0; block2 all zero except [479:448]=32'h1C0.
//  64 bytes => full block (blk_last=0), then block with byte0=0x80, [479:448]=32'h200, blk_last=1.
//  blk_ready held 0 for 10 cycles => blk_data stable, in_ready=0; then rst mid-FILL => empty state.

Source files
------------

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - shared state encoding, block constants and length helper for md5_pad
package md5_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        FIN    = 2'd1,
        EMIT   = 2'd2,
        LENBLK = 2'd3
    } state_t;

    localparam int          MD5_BLK_BYTES = 64;
    localparam int          MD5_LEN_OFS   = 56;
    localparam logic [7:0]  MD5_PAD_BYTE  = 8'h80;

    // Byte count to bit count; the buffer places it little-endian at MD5_LEN_OFS.
    function automatic logic [63:0] len_bytes(input logic [63:0] count);
        return count << 3;
    endfunction

endpackage

// File: rtl/md5_pad_buf.sv
// rtl/md5_pad_buf.sv - 64x8 block buffer with byte write, 8-byte length write and clear
module md5_pad_buf
    import md5_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [5:0]                   wr_idx,
    input  logic [7:0]                   wr_data,
    input  logic                         len_en,
    input  logic [63:0]                  len_data,
    output logic [MD5_BLK_BYTES*8-1:0]   data
);

    // Clearing wins: padding zeros rely on the buffer being wiped after every block.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            data <= '0;
        end else begin
            if (wr_en) begin
                data[{wr_idx, 3'b000} +: 8] <= wr_data;
            end
            if (len_en) begin
                data[MD5_LEN_OFS*8 +: 64] <= len_data;
            end
        end
    end

endmodule

// File: rtl/md5_pad.sv
// rtl/md5_pad.sv - MD5 byte-stream padder emitting 512-bit blocks; MD5_PAD_MAXLEN_CHK_EN enables the length limit
module md5_pad
    import md5_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int MAX_BYTES = 2**20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_bytevld,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic         err
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam logic [5:0]       IDX_LAST = 6'(MD5_BLK_BYTES - 1);
    localparam logic [5:0]       IDX_LEN  = 6'(MD5_LEN_OFS);

    state_t             state, state_nx;
    logic [5:0]         idx;
    logic [CNT_W-1:0]   cnt;
    logic               last_r;
    logic               pend_fin;
    logic               pend_len;
    logic               acc;
    logic               take;
    logic               drop;
    logic               buf_wr;
    logic               buf_len;
    logic               buf_clr;
    logic [7:0]         buf_wdata;

    assign acc = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        take      = 1'b0;
        buf_wr    = 1'b0;
        buf_len   = 1'b0;
        buf_clr   = 1'b0;
        buf_wdata = in_data;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                take     = acc & in_bytevld & ~drop;
                buf_wr   = take;
                // A last byte that fills the block still emits the full block first.
                if (take && idx == IDX_LAST) begin
                    state_nx = EMIT;
                end else if (acc && in_last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                buf_wr    = 1'b1;
                buf_wdata = MD5_PAD_BYTE;
                buf_len   = (idx < IDX_LEN);
                state_nx  = EMIT;
            end
            EMIT: begin
                blk_valid = 1'b1;
                buf_clr   = blk_ready;
                if (blk_ready) begin
                    if (pend_fin) begin
                        state_nx = FIN;
                    end else if (pend_len) begin
                        state_nx = LENBLK;
                    end else begin
                        state_nx = FILL;
                    end
                end
            end
            LENBLK: begin
                buf_len  = 1'b1;
                state_nx = EMIT;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            cnt      <= '0;
            last_r   <= 1'b0;
            pend_fin <= 1'b0;
            pend_len <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (take) begin
                        idx <= idx + 6'd1;
                        if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (idx == IDX_LAST && in_last) begin
                            pend_fin <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    pend_fin <= 1'b0;
                    if (idx < IDX_LEN) begin
                        last_r <= 1'b1;
                    end else begin
                        last_r   <= 1'b0;
                        pend_len <= 1'b1;
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        idx    <= '0;
                        last_r <= 1'b0;
                        if (last_r) begin
                            cnt <= '0;
                        end
                        if (!pend_fin) begin
                            pend_len <= 1'b0;
                        end
                    end
                end
                LENBLK: last_r <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MD5_PAD_MAXLEN_CHK_EN
    logic err_r;

    assign drop = (cnt == MAX_CNT);
    assign err  = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (acc && in_bytevld && drop) begin
            err_r <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign drop       = 1'b0;
    assign err        = 1'b0;
    assign unused_cfg = ^MAX_CNT;
`endif

    md5_pad_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (buf_clr),
        .wr_en    (buf_wr),
        .wr_idx   (idx),
        .wr_data  (buf_wdata),
        .len_en   (buf_len),
        .len_data (len_bytes(64'(cnt))),
        .data     (blk_data)
    );

    assign blk_last = last_r;

endmodule

// File: tb/tb_md5_pad.sv
// tb/tb_md5_pad.sv - scoreboard bench for md5_pad against a padded-message reference model
module tb_md5_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_bytevld;
    logic         in_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         err;

    typedef struct {
        logic [511:0] d;
        logic         l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   hold_ready  = 1'b0;

    md5_pad dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_bytevld (in_bytevld),
        .in_last    (in_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(string nm, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endfunction

    // Reference: message, 0x80, zeros to 56 mod 64, then 64-bit LE bit length.
    task automatic model_push(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        exp_t        e;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            for (int i = 0; i < 64; i++) e.d[8*i +: 8] = p[64*b + i];
            e.l = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic bv, input logic last);
        int n;
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid   = 1'b1;
        in_data    = d;
        in_bytevld = bv;
        in_last    = last;
        n = 0;
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit bare);
        model_push(msg);
        for (int i = 0; i < msg.size(); i++)
            send_beat(msg[i], 1'b1, (!bare && i == msg.size() - 1));
        if (bare || msg.size() == 0)
            send_beat(8'($urandom), 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic seq_msg(input int len, input int base, input bit bare);
        logic [7:0] m[$];
        for (int i = 0; i < len; i++) m.push_back(8'(base + i));
        send_msg(m, bare);
        wait_idle();
    endtask

    initial begin
        blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            blk_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && blk_valid) begin
                chk1("in_ready_during_emit", in_ready, 1'b0);
                if (blk_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_block: got %h expected none", blk_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("blk_data", blk_data, mon_e.d);
                        chk1("blk_last", blk_last, mon_e.l);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        int         n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_bytevld = 1'b0;
        in_last    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_blk_valid", blk_valid, 1'b0);
        chk1("rst_blk_last", blk_last, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_blk_data", blk_data, 512'h0);

        // "abc"
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_idle();

        // empty message: block visible two cycles after the terminator beat
        m = {};
        send_msg(m, 1'b1);
        chk1("empty_valid_t1", blk_valid, 1'b0);
        @(negedge clk);
        chk1("empty_valid_t2", blk_valid, 1'b1);
        wait_idle();

        seq_msg(55, 0, 1'b0);
        seq_msg(56, 0, 1'b0);
        seq_msg(64, 0, 1'b0);
        seq_msg(63, 7, 1'b1);
        seq_msg(64, 9, 1'b1);
        seq_msg(120, 3, 1'b0);

        // stalled core: block held, no input accepted
        hold_ready = 1'b1;
        @(posedge clk);
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        n = 0;
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("stall_valid", blk_valid, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_data", blk_data, exp_q[0].d);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        hold_ready = 1'b0;
        wait_idle();

        // reset mid-FILL discards the partial message
        for (int i = 0; i < 20; i++) send_beat(8'($urandom), 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_blk_valid", blk_valid, 1'b0);
        chk1("midrst_blk_last", blk_last, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk("midrst_blk_data", blk_data, 512'h0);
        rst = 1'b0;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        wait_idle();

        // randomized messages
        repeat (25) begin
            m = {};
            n = $urandom_range(0, 150);
            for (int i = 0; i < n; i++) m.push_back(8'($urandom));
            send_msg(m, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        wait_idle();
        chk1("final_err", err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
